// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the 4-bit ALU datapath blocks.
//   - Default operand width and shift-amount width.
//   - FSM state encodings for the sequential shifter. The enum is built on the
//     ST_* localparams so checkers can compare against stable numeric codes.
//   - Shift mode constants: MODE_LSL (zero fill), MODE_ROL (rotate).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int AMT_W_DEF = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic MODE_LSL = 1'b0;
    localparam logic MODE_ROL = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } shl_state_t;

endpackage : alu_pkg

// File: rtl/shl_seq_unit_step.sv
// -----------------------------------------------------------------------------
// shl_step
//   Combinational single-bit left shift / rotate stage.
//
//   Ports:
//     i_reg   [WIDTH-1:0]  current work value
//     i_rot                MODE_LSL: zero fill, MODE_ROL: MSB wraps to LSB
//     o_next  [WIDTH-1:0]  value after one left step
//     o_out                bit leaving the MSB (becomes carry-out)
//     o_ovf                signed-overflow contribution of this step; the sign
//                          changes when the two top bits differ. Only
//                          meaningful for logical shifts, so forced low for
//                          rotates.
// -----------------------------------------------------------------------------
module shl_step
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] i_reg,
    input  logic             i_rot,
    output logic [WIDTH-1:0] o_next,
    output logic             o_out,
    output logic             o_ovf
);

    logic w_fill;

    assign o_out  = i_reg[WIDTH-1];
    assign w_fill = (i_rot == MODE_ROL) ? i_reg[WIDTH-1] : 1'b0;
    assign o_next = {i_reg[WIDTH-2:0], w_fill};
    assign o_ovf  = (i_rot == MODE_LSL) & (i_reg[WIDTH-1] ^ i_reg[WIDTH-2]);

endmodule : shl_step

// File: rtl/shl_seq_unit.sv
// -----------------------------------------------------------------------------
// shl_seq_unit
//   Multi-cycle left shifter / rotator, one bit per clock.
//
//   Handshake: start is sampled only in IDLE. On an accepted start, A, amt and
//   rot are captured, busy rises on the next cycle and stays high through the
//   single DONE cycle, during which done pulses for exactly one clock. start
//   seen in SHIFT or DONE is dropped, never queued. Results (Y, cout, ovf,
//   zero) are valid from the done cycle and held until the next accepted start.
//
//   Ports:
//     clk, rst          rising-edge clock, async active-high reset
//     start             operation request
//     A     [WIDTH-1:0] operand
//     amt   [AMT_W-1:0] shift amount, 0..2^AMT_W-1 (each step takes a cycle)
//     rot               0 = logical shift left, 1 = rotate left
//     busy              operation in progress (SHIFT or DONE)
//     done              one-cycle result-valid pulse
//     Y     [WIDTH-1:0] result (the work register)
//     cout              last bit shifted out of the MSB
//     ovf               sticky signed overflow (logical shifts only)
//     zero              Y == 0, qualified by a completed result
//     o_dbg_state [1:0] current FSM state code (ST_* in alu_pkg)
// -----------------------------------------------------------------------------
module shl_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [AMT_W-1:0] amt,
    input  logic             rot,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [1:0]       o_dbg_state
);

    shl_state_t       r_state;
    shl_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_work;
    logic [AMT_W-1:0] r_cnt;
    logic             r_mode;
    logic             r_cout;
    logic             r_ovf;
    // Marks that r_work holds a finished result; keeps zero low out of reset
    // even though the work register is cleared to 0.
    logic             r_valid;

    logic [WIDTH-1:0] w_next;
    logic             w_out;
    logic             w_ovf;

    shl_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_reg  (r_work),
        .i_rot  (r_mode),
        .o_next (w_next),
        .o_out  (w_out),
        .o_ovf  (w_ovf)
    );

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (amt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                // r_cnt holds the steps still to do including this one.
                if (r_cnt == AMT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_mode  <= MODE_LSL;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work  <= A;
                        r_cnt   <= amt;
                        r_mode  <= rot;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_valid <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_work <= w_next;
                    r_cout <= w_out;
                    r_ovf  <= r_ovf | w_ovf;
                    r_cnt  <= r_cnt - AMT_W'(1);
                end
                default: begin
                end
            endcase
            // Overrides the clear above for amt==0, which goes straight to DONE.
            if (w_state_nxt == S_DONE) begin
                r_valid <= 1'b1;
            end
        end
    end

    assign busy        = (r_state == S_SHIFT) || (r_state == S_DONE);
    assign done        = (r_state == S_DONE);
    assign Y           = r_work;
    assign cout        = r_cout;
    assign ovf         = r_ovf;
    assign zero        = r_valid & (r_work == '0);
    assign o_dbg_state = r_state;

endmodule : shl_seq_unit
